// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use, branch-in-ID and divider stall control for the 5-stage core.
// All outputs are combinational from the inputs and the divider FSM state.
module hazard_stall_unit #(
    parameter int unsigned DIV_LATENCY = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_address_id_i,
    input  logic [4:0] rs2_address_id_i,
    input  logic       rs1_in_use_i,
    input  logic       rs2_in_use_i,
    input  logic       branch_id_i,
    input  logic       branch_taken_id_i,
    input  logic [4:0] rd_address_ex_i,
    input  logic       reg_write_ex_i,
    input  logic       mem_to_reg_ex_i,
    input  logic [4:0] rd_address_mem_i,
    input  logic       mem_to_reg_mem_i,
    input  logic       div_start_ex_i,
    output logic       pc_en_o,
    output logic       if_id_en_o,
    output logic       id_ex_en_o,
    output logic       control_pass_o,
    output logic       ex_mem_bubble_o,
    output logic       if_id_flush_o,
    output logic       div_busy_o,
    output logic       div_done_o
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    localparam logic [5:0] LAT_M1 = 6'(DIV_LATENCY - 1);
    state_t     r_state, w_state_nx;
    logic [5:0] r_cnt, w_cnt_nx;
    logic       w_ex1, w_ex2, w_mem1, w_mem2;
    logic       w_load_use, w_branch_haz, w_haz, w_div_stall;
    assign w_ex1  = rs1_in_use_i && rs1_address_id_i != 5'd0 && rs1_address_id_i == rd_address_ex_i;
    assign w_ex2  = rs2_in_use_i && rs2_address_id_i != 5'd0 && rs2_address_id_i == rd_address_ex_i;
    assign w_mem1 = rs1_in_use_i && rs1_address_id_i != 5'd0 && rs1_address_id_i == rd_address_mem_i;
    assign w_mem2 = rs2_in_use_i && rs2_address_id_i != 5'd0 && rs2_address_id_i == rd_address_mem_i;
    assign w_load_use   = mem_to_reg_ex_i && (w_ex1 || w_ex2);
    assign w_branch_haz = branch_id_i && ((reg_write_ex_i && (w_ex1 || w_ex2)) ||
                                         (mem_to_reg_mem_i && (w_mem1 || w_mem2)));
    assign w_haz        = w_load_use || w_branch_haz;
    // The first stall cycle is combinational so the divide is held in EX on entry.
    assign w_div_stall  = !reset && ((r_state == S_IDLE && div_start_ex_i) || r_state == S_BUSY);
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: if (div_start_ex_i) begin
                w_state_nx = (DIV_LATENCY == 1) ? S_DONE : S_BUSY;
                w_cnt_nx   = LAT_M1;
            end
            S_BUSY: begin
                w_cnt_nx   = r_cnt - 6'd1;
                w_state_nx = (r_cnt == 6'd1) ? S_DONE : S_BUSY;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end
    assign pc_en_o         = reset || !(w_div_stall || w_haz);
    assign if_id_en_o      = pc_en_o;
    assign id_ex_en_o      = reset || !w_div_stall;
    assign control_pass_o  = !reset && (w_div_stall || !w_haz);
    assign ex_mem_bubble_o = w_div_stall;
    assign if_id_flush_o   = !reset && branch_taken_id_i && pc_en_o;
    assign div_busy_o      = w_div_stall;
    assign div_done_o      = !reset && r_state == S_DONE;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of hazard stalls, flush and divider sequencing.
module tb_hazard_stall_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1, rs2, rd_ex, rd_mem;
    logic       rs1_use, rs2_use, br, br_taken, rw_ex, ld_ex, ld_mem, div_start;
    logic [7:0] o4, o1;
    int         checks = 0;
    int         failures = 0;
    // Output vector order: pc, if_id, id_ex, control_pass, ex_mem_bubble, flush, busy, done
    localparam logic [7:0] P_RST  = 8'b11100_000;
    localparam logic [7:0] P_NORM = 8'b11110_000;
    localparam logic [7:0] P_FL   = 8'b11110_100;
    localparam logic [7:0] P_HAZ  = 8'b00100_000;
    localparam logic [7:0] P_DIV  = 8'b00011_010;
    localparam logic [7:0] P_DONE = 8'b11110_001;
    always #5 clk = ~clk;
    hazard_stall_unit #(.DIV_LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .rs1_address_id_i(rs1), .rs2_address_id_i(rs2),
        .rs1_in_use_i(rs1_use), .rs2_in_use_i(rs2_use),
        .branch_id_i(br), .branch_taken_id_i(br_taken),
        .rd_address_ex_i(rd_ex), .reg_write_ex_i(rw_ex), .mem_to_reg_ex_i(ld_ex),
        .rd_address_mem_i(rd_mem), .mem_to_reg_mem_i(ld_mem), .div_start_ex_i(div_start),
        .pc_en_o(o4[7]), .if_id_en_o(o4[6]), .id_ex_en_o(o4[5]), .control_pass_o(o4[4]),
        .ex_mem_bubble_o(o4[3]), .if_id_flush_o(o4[2]), .div_busy_o(o4[1]), .div_done_o(o4[0])
    );
    hazard_stall_unit #(.DIV_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .rs1_address_id_i(rs1), .rs2_address_id_i(rs2),
        .rs1_in_use_i(rs1_use), .rs2_in_use_i(rs2_use),
        .branch_id_i(br), .branch_taken_id_i(br_taken),
        .rd_address_ex_i(rd_ex), .reg_write_ex_i(rw_ex), .mem_to_reg_ex_i(ld_ex),
        .rd_address_mem_i(rd_mem), .mem_to_reg_mem_i(ld_mem), .div_start_ex_i(div_start),
        .pc_en_o(o1[7]), .if_id_en_o(o1[6]), .id_ex_en_o(o1[5]), .control_pass_o(o1[4]),
        .ex_mem_bubble_o(o1[3]), .if_id_flush_o(o1[2]), .div_busy_o(o1[1]), .div_done_o(o1[0])
    );
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic step4(input string tag, input logic [7:0] exp);
        #1 chk(tag, o4, exp);
        @(posedge clk);
        #1;
    endtask
    task automatic step1(input string tag, input logic [7:0] exp);
        #1 chk(tag, o1, exp);
        @(posedge clk);
        #1;
    endtask
    task automatic clr();
        rs1 = 5'd0; rs2 = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
        rs1_use = 1'b0; rs2_use = 1'b0; br = 1'b0; br_taken = 1'b0;
        rw_ex = 1'b0; ld_ex = 1'b0; ld_mem = 1'b0; div_start = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        clr();
        step4("reset", P_RST);
        div_start = 1'b1; rs1 = 5'd3; rs1_use = 1'b1; rd_ex = 5'd3; ld_ex = 1'b1;
        step4("reset_forces", P_RST);
        reset = 1'b0;
        clr();
        step4("idle", P_NORM);
        rd_ex = 5'd5; rw_ex = 1'b1; ld_ex = 1'b1; rs1 = 5'd5; rs2 = 5'd1; rs1_use = 1'b1; rs2_use = 1'b1;
        step4("load_use", P_HAZ);
        rd_ex = 5'd0; rw_ex = 1'b0; ld_ex = 1'b0; rd_mem = 5'd5; ld_mem = 1'b1;
        step4("load_use_after", P_NORM);
        clr();
        rd_ex = 5'd0; rw_ex = 1'b1; ld_ex = 1'b1; rs1 = 5'd0; rs1_use = 1'b1;
        step4("load_x0", P_NORM);
        rd_ex = 5'd5; rs2 = 5'd5; rs2_use = 1'b0;
        step4("load_rs2_unused", P_NORM);
        rs2_use = 1'b1;
        step4("load_use_rs2", P_HAZ);
        clr();
        br = 1'b1; br_taken = 1'b1; rs1 = 5'd7; rs2 = 5'd2; rs1_use = 1'b1; rs2_use = 1'b1;
        rd_ex = 5'd7; rw_ex = 1'b1;
        step4("br_alu_stall", P_HAZ);
        rd_ex = 5'd0; rw_ex = 1'b0; rd_mem = 5'd7;
        step4("br_alu_resolve", P_FL);
        rd_ex = 5'd7; rw_ex = 1'b1; ld_ex = 1'b1; rd_mem = 5'd0; br_taken = 1'b0;
        step4("br_load_ex", P_HAZ);
        rd_ex = 5'd0; rw_ex = 1'b0; ld_ex = 1'b0; rd_mem = 5'd7; ld_mem = 1'b1;
        step4("br_load_mem", P_HAZ);
        ld_mem = 1'b0;
        step4("br_load_go", P_NORM);
        rd_mem = 5'd0; br_taken = 1'b1;
        step4("taken_flush", P_FL);
        br_taken = 1'b0;
        step4("taken_clear", P_NORM);
        clr();
        div_start = 1'b1; rd_ex = 5'd5; rw_ex = 1'b1;
        br = 1'b1; rs1 = 5'd5; rs1_use = 1'b1;
        step4("div_t0", P_DIV);
        step4("div_t1", P_DIV);
        step4("div_t2", P_DIV);
        step4("div_t3", P_DIV);
        step4("div_done_haz", 8'b00100_001);
        div_start = 1'b0; rd_ex = 5'd0; rw_ex = 1'b0; rd_mem = 5'd5;
        step4("div_after", P_NORM);
        clr();
        div_start = 1'b1;
        step4("abort_t0", P_DIV);
        step4("abort_t1", P_DIV);
        reset = 1'b1;
        step4("abort_reset", P_RST);
        reset = 1'b0; div_start = 1'b0;
        step4("abort_no_done", P_NORM);
        step4("abort_idle", P_NORM);
        div_start = 1'b1;
        step4("restart_t0", P_DIV);
        step4("restart_t1", P_DIV);
        step4("restart_t2", P_DIV);
        step4("restart_t3", P_DIV);
        step4("restart_done", P_DONE);
        clr();
        reset = 1'b1;
        step1("lat1_reset", P_RST);
        reset = 1'b0; div_start = 1'b1;
        step1("lat1_a_stall", P_DIV);
        step1("lat1_a_done", P_DONE);
        step1("lat1_b_stall", P_DIV);
        step1("lat1_b_done", P_DONE);
        div_start = 1'b0;
        step1("lat1_idle", P_NORM);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
